// File: rtl/tia_hsync_if.sv
// Strobe and timing-output bundle between the TIA horizontal sequencer and its neighbours.
interface tia_hsync_if;
   // rsync/wsync/hmove are single-clock strobes with no ready: a strobe is taken on the
   // rising clk edge where it is high and must return low before the next edge.
   // All outputs are registered or decoded from registers and valid for the whole clk.
   logic       rsync;
   logic       wsync;
   logic       hmove;
   logic       phi1_en;
   logic       phi2_en;
   logic [5:0] hcount;
   logic       hsync;
   logic       hblank;
   logic       cburst;
   logic       rdy;
   logic       line_start;
   logic [1:0] phase;

   modport master (
      output rsync, wsync, hmove,
      input  phi1_en, phi2_en, hcount, hsync, hblank, cburst, rdy, line_start, phase
   );

   modport slave (
      input  rsync, wsync, hmove,
      output phi1_en, phi2_en, hcount, hsync, hblank, cburst, rdy, line_start, phase
   );
endinterface

// File: rtl/tia_hsync_sequencer.sv
// TIA horizontal timing: phi1/phi2 phase generator, 57-state line counter and the
// HSYNC/CBURST/HBLANK windows with RSYNC, WSYNC and HMOVE handling.
module tia_hsync_sequencer #(
   parameter int LINE_LAST = 56,
   parameter int SET_HS    = 4,
   parameter int RES_HS    = 8,
   parameter int RES_CB    = 12,
   parameter int RES_HB    = 16,
   parameter int LRES_HB   = 18
) (
   input  logic       clk,
   input  logic       r_n,
   tia_hsync_if.slave hs
);

   localparam logic [5:0] LAST_C    = 6'(LINE_LAST);
   localparam logic [5:0] SET_HS_C  = 6'(SET_HS);
   localparam logic [5:0] RES_HS_C  = 6'(RES_HS);
   localparam logic [5:0] RES_CB_C  = 6'(RES_CB);
   localparam logic [5:0] RES_HB_C  = 6'(RES_HB);
   localparam logic [5:0] LRES_HB_C = 6'(LRES_HB);

   logic [1:0] phase_q, phase_d;
   logic [5:0] hcount_q, hcount_d;
   logic       hsync_q, hsync_d;
   logic       hblank_q, hblank_d;
   logic       cburst_q, cburst_d;
   logic       rdy_q, rdy_d;
   logic       line_start_q, line_start_d;
   logic       hmove_pend_q, hmove_pend_d;
   logic [5:0] cnt_nxt;

   // State register
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         phase_q      <= 2'd0;
         hcount_q     <= 6'd0;
         hsync_q      <= 1'b0;
         hblank_q     <= 1'b1;
         cburst_q     <= 1'b0;
         rdy_q        <= 1'b1;
         line_start_q <= 1'b0;
         hmove_pend_q <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         hcount_q     <= hcount_d;
         hsync_q      <= hsync_d;
         hblank_q     <= hblank_d;
         cburst_q     <= cburst_d;
         rdy_q        <= rdy_d;
         line_start_q <= line_start_d;
         hmove_pend_q <= hmove_pend_d;
      end
   end

   assign cnt_nxt = (hcount_q == LAST_C) ? 6'd0 : hcount_q + 6'd1;

   // Next-state logic; window flags decode the count being entered on this phi2 edge
   always_comb begin
      phase_d      = phase_q + 2'd1;
      hcount_d     = hcount_q;
      hsync_d      = hsync_q;
      hblank_d     = hblank_q;
      cburst_d     = cburst_q;
      rdy_d        = rdy_q;
      line_start_d = 1'b0;
      hmove_pend_d = hmove_pend_q;
      if (hs.rsync) begin
         // Re-enter one phase ahead so the first phi2 edge comes two clocks later
         phase_d      = 2'd1;
         hcount_d     = 6'd0;
         hsync_d      = 1'b0;
         hblank_d     = 1'b1;
         cburst_d     = 1'b0;
         rdy_d        = 1'b1;
         line_start_d = 1'b1;
         hmove_pend_d = 1'b0;
      end else begin
         if (phase_q == 2'd2) begin
            hcount_d = cnt_nxt;
            if (cnt_nxt == 6'd0) begin
               hblank_d     = 1'b1;
               hsync_d      = 1'b0;
               cburst_d     = 1'b0;
               line_start_d = 1'b1;
               hmove_pend_d = 1'b0;
               rdy_d        = 1'b1;
            end
            if (cnt_nxt == SET_HS_C) hsync_d = 1'b1;
            if (cnt_nxt == RES_HS_C) begin
               hsync_d  = 1'b0;
               cburst_d = 1'b1;
            end
            if (cnt_nxt == RES_CB_C) cburst_d = 1'b0;
            if (cnt_nxt == RES_HB_C && !hmove_pend_q) hblank_d = 1'b0;
            if (cnt_nxt == LRES_HB_C && hmove_pend_q) hblank_d = 1'b0;
         end
         // Strobes override the wrap-edge clear so they carry into the new line
         if (hs.wsync) rdy_d = 1'b0;
         if (hs.hmove) hmove_pend_d = 1'b1;
      end
   end

   // Output decode
   always_comb begin
      hs.phi1_en    = (phase_q == 2'd0);
      hs.phi2_en    = (phase_q == 2'd2);
      hs.hcount     = hcount_q;
      hs.hsync      = hsync_q;
      hs.hblank     = hblank_q;
      hs.cburst     = cburst_q;
      hs.rdy        = rdy_q;
      hs.line_start = line_start_q;
      hs.phase      = phase_q;
   end

endmodule

// File: tb/tb_tia_hsync_sequencer.sv
// Bench for tia_hsync_sequencer: timing table, directed strobe sequences and random
// strobes compared each clock against a line-position reference model.
module tb_tia_hsync_sequencer;

   localparam int LINE_CLKS = 228;
   localparam int N_TBL     = 16;

   typedef struct {
      int         edge_no;
      logic [5:0] hc;
      logic       hs;
      logic       cb;
      logic       hb;
      logic       rdy;
      logic       ls;
   } vec_t;

   logic clk = 1'b0;
   logic r_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   edge_n = 0;
   logic [14:0] exp_q[$];
   vec_t tbl[N_TBL];

   // Reference model state: position within the line in clocks, plus line-level flags
   int m_p;
   bit m_pend, m_late, m_rdy, m_ls;

   tia_hsync_if hs_if ();

   tia_hsync_sequencer dut (
      .clk (clk),
      .r_n (r_n),
      .hs  (hs_if.slave)
   );

   // Clock / reset
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_p = 0; m_pend = 0; m_late = 0; m_rdy = 1; m_ls = 0;
   endfunction

   function automatic void model_edge(input bit rs, input bit ws, input bit hm);
      if (rs) begin
         m_p = 1; m_pend = 0; m_late = 0; m_rdy = 1; m_ls = 1;
      end else begin
         m_p  = (m_p + 1) % LINE_CLKS;
         m_ls = (m_p == LINE_CLKS - 1);
         if (m_p == 63) m_late = m_pend;
         if (m_p == LINE_CLKS - 1) begin
            m_rdy = 1; m_pend = 0; m_late = 0;
         end
         if (ws) m_rdy = 0;
         if (hm) m_pend = 1;
      end
   endfunction

   function automatic logic [14:0] model_vec();
      int hc;
      logic hsv, cbv, hbv;
      hc  = ((m_p + 1) / 4) % 57;
      hsv = (hc >= 4 && hc < 8);
      cbv = (hc >= 8 && hc < 12);
      hbv = (hc < 16) || (hc < 18 && m_late);
      return {2'(m_p % 4), (m_p % 4 == 0), (m_p % 4 == 2), 6'(hc), hsv, hbv, cbv, m_rdy, m_ls};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {hs_if.phase, hs_if.phi1_en, hs_if.phi2_en, hs_if.hcount, hs_if.hsync,
              hs_if.hblank, hs_if.cburst, hs_if.rdy, hs_if.line_start};
   endfunction

   task automatic expect_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%h want=%h", name, edge_n, act, exp);
      end
   endtask

   // Scoreboard: one model expectation per clock, popped and compared after the edge
   task automatic check_cycle();
      logic [14:0] exp;
      exp = exp_q.pop_front();
      expect_val("cycle", {1'b0, dut_vec()}, {1'b0, exp});
   endtask

   // Driver tasks
   task automatic step(input bit rs, input bit ws, input bit hm);
      hs_if.rsync = rs;
      hs_if.wsync = ws;
      hs_if.hmove = hm;
      @(posedge clk);
      edge_n++;
      model_edge(rs, ws, hm);
      exp_q.push_back(model_vec());
      #1;
      hs_if.rsync = 1'b0;
      hs_if.wsync = 1'b0;
      hs_if.hmove = 1'b0;
      check_cycle();
   endtask

   task automatic run_to(input int e, input bit rs, input bit ws, input bit hm);
      while (edge_n < e - 1) step(1'b0, 1'b0, 1'b0);
      step(rs, ws, hm);
   endtask

   task automatic do_reset();
      hs_if.rsync = 1'b0;
      hs_if.wsync = 1'b0;
      hs_if.hmove = 1'b0;
      r_n = 1'b0;
      #1;
      // phase 0, phi1 1, phi2 0, hcount 0, hsync 0, hblank 1, cburst 0, rdy 1, line_start 0
      expect_val("reset_state", {1'b0, dut_vec()}, {1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
      @(posedge clk);
      @(negedge clk);
      r_n = 1'b1;
      model_reset();
      edge_n = 0;
   endtask

   task automatic run_table();
      for (int i = 0; i < N_TBL; i++) begin
         while (edge_n < tbl[i].edge_no) step(1'b0, 1'b0, 1'b0);
         expect_val($sformatf("tbl_e%0d", tbl[i].edge_no),
                    {6'd0, hs_if.hcount, hs_if.hsync, hs_if.cburst, hs_if.hblank, hs_if.rdy, hs_if.line_start},
                    {6'd0, tbl[i].hc, tbl[i].hs, tbl[i].cb, tbl[i].hb, tbl[i].rdy, tbl[i].ls});
      end
   endtask

   initial begin
      //          edge  hcount  hs cb hb rdy ls
      tbl[0]  = '{1,   6'd0,  0, 0, 1, 1, 0};
      tbl[1]  = '{3,   6'd1,  0, 0, 1, 1, 0};
      tbl[2]  = '{14,  6'd3,  0, 0, 1, 1, 0};
      tbl[3]  = '{15,  6'd4,  1, 0, 1, 1, 0};
      tbl[4]  = '{30,  6'd7,  1, 0, 1, 1, 0};
      tbl[5]  = '{31,  6'd8,  0, 1, 1, 1, 0};
      tbl[6]  = '{46,  6'd11, 0, 1, 1, 1, 0};
      tbl[7]  = '{47,  6'd12, 0, 0, 1, 1, 0};
      tbl[8]  = '{62,  6'd15, 0, 0, 1, 1, 0};
      tbl[9]  = '{63,  6'd16, 0, 0, 0, 1, 0};
      tbl[10] = '{226, 6'd56, 0, 0, 0, 1, 0};
      tbl[11] = '{227, 6'd0,  0, 0, 1, 1, 1};
      tbl[12] = '{228, 6'd0,  0, 0, 1, 1, 0};
      tbl[13] = '{243, 6'd4,  1, 0, 1, 1, 0};
      tbl[14] = '{291, 6'd16, 0, 0, 0, 1, 0};
      tbl[15] = '{455, 6'd0,  0, 0, 1, 1, 1};

      hs_if.rsync = 1'b0;
      hs_if.wsync = 1'b0;
      hs_if.hmove = 1'b0;
      #2;

      // Free run over two lines
      do_reset();
      run_table();

      // wsync mid-line, released at wrap
      do_reset();
      run_to(100, 0, 1, 0); expect_val("wsync_rdy_low", 16'(hs_if.rdy), 16'd0);
      run_to(226, 0, 0, 0); expect_val("wsync_rdy_hold", 16'(hs_if.rdy), 16'd0);
      run_to(227, 0, 0, 0); expect_val("wsync_rdy_wrap", 16'(hs_if.rdy), 16'd1);

      // wsync on the wrap edge wins over the wrap release
      do_reset();
      run_to(227, 0, 1, 0); expect_val("wsync_at_wrap", 16'(hs_if.rdy), 16'd0);
      run_to(454, 0, 0, 0); expect_val("wsync_wrap_hold", 16'(hs_if.rdy), 16'd0);
      run_to(455, 0, 0, 0); expect_val("wsync_wrap_rel", 16'(hs_if.rdy), 16'd1);

      // hmove before hblank end delays it by two counts, for this line only
      do_reset();
      run_to(20, 0, 0, 1);
      run_to(63, 0, 0, 0);  expect_val("hmove_hb_63", 16'(hs_if.hblank), 16'd1);
      run_to(70, 0, 0, 0);  expect_val("hmove_hb_70", 16'(hs_if.hblank), 16'd1);
      run_to(71, 0, 0, 0);  expect_val("hmove_hb_71", 16'(hs_if.hblank), 16'd0);
      run_to(290, 0, 0, 0); expect_val("hmove_next_290", 16'(hs_if.hblank), 16'd1);
      run_to(291, 0, 0, 0); expect_val("hmove_next_291", 16'(hs_if.hblank), 16'd0);

      // hmove after hblank end is discarded
      do_reset();
      run_to(80, 0, 0, 1);  expect_val("late_hmove_hb", 16'(hs_if.hblank), 16'd0);
      run_to(290, 0, 0, 0); expect_val("late_hmove_290", 16'(hs_if.hblank), 16'd1);
      run_to(291, 0, 0, 0); expect_val("late_hmove_291", 16'(hs_if.hblank), 16'd0);

      // rsync with simultaneous wsync and hmove
      do_reset();
      run_to(100, 0, 1, 0);
      run_to(150, 1, 1, 1);
      expect_val("rsync_now",
                 {11'd0, hs_if.hcount[3:0], hs_if.hblank},
                 {11'd0, 4'd0, 1'b1});
      expect_val("rsync_rdy_ls", {14'd0, hs_if.rdy, hs_if.line_start}, {14'd0, 1'b1, 1'b1});
      run_to(151, 0, 0, 0); expect_val("rsync_151", {9'd0, hs_if.hcount, hs_if.line_start}, 16'd0);
      run_to(152, 0, 0, 0); expect_val("rsync_hc1", 16'(hs_if.hcount), 16'd1);
      run_to(163, 0, 0, 0); expect_val("rsync_hs_163", 16'(hs_if.hsync), 16'd0);
      run_to(164, 0, 0, 0); expect_val("rsync_hs_164", 16'(hs_if.hsync), 16'd1);
      run_to(211, 0, 0, 0); expect_val("rsync_hb_211", 16'(hs_if.hblank), 16'd1);
      run_to(212, 0, 0, 0); expect_val("rsync_hb_212", 16'(hs_if.hblank), 16'd0);

      // Asynchronous reset mid-line, then identical timing to the first run
      do_reset();
      run_to(40, 0, 0, 0);
      expect_val("pre_reset_cb", 16'(hs_if.cburst), 16'd1);
      do_reset();
      run_table();

      // Random strobes against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
